// File: rtl/gf180mcu_fd_sc_mcu9t5v0__antenna_sync_filter.sv
// Input conditioner for antenna-protected nets entering the core clock domain.
// Per channel: synchroniser, persistence deglitch filter, edge pulses, sticky glitch flag.
module gf180mcu_fd_sc_mcu9t5v0__antenna_sync_filter #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILT_CNT    = 3,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  input  logic             CLR,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] GLITCH,
  output logic             CHG
);

  localparam int unsigned   CW   = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_pulse;
  logic             r_chg;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= INIT;
      end
    end else begin
      r_sync[0] <= I;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_z;
    logic          r_rise;
    logic          r_fall;
    logic          r_glitch;

    logic          w_pend;
    logic          w_hit;
    logic          w_step;
    logic          w_abort;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_z_nxt;
    logic          w_rise_nxt;
    logic          w_fall_nxt;
    logic          w_glitch_nxt;

    assign w_pend  = w_s[g] ^ r_z;
    assign w_hit   = w_pend && (r_cnt == LAST);
    assign w_step  = w_pend && !w_hit;
    assign w_abort = !w_pend && (r_cnt != '0);

    always_comb begin
      w_cnt_nxt    = r_cnt;
      w_z_nxt      = r_z;
      w_rise_nxt   = 1'b0;
      w_fall_nxt   = 1'b0;
      w_glitch_nxt = r_glitch & ~CLR;
      if (!EN) begin
        // a pend dropped by EN is not a glitch
        w_cnt_nxt = '0;
      end else begin
        unique case (1'b1)
          w_hit: begin
            w_cnt_nxt  = '0;
            w_z_nxt    = w_s[g];
            w_rise_nxt = w_s[g];
            w_fall_nxt = ~w_s[g];
          end
          w_step: begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
          w_abort: begin
            w_cnt_nxt    = '0;
            w_glitch_nxt = 1'b1;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        r_cnt    <= '0;
        r_z      <= INIT[g];
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_glitch <= 1'b0;
      end else begin
        r_cnt    <= w_cnt_nxt;
        r_z      <= w_z_nxt;
        r_rise   <= w_rise_nxt;
        r_fall   <= w_fall_nxt;
        r_glitch <= w_glitch_nxt;
      end
    end

    assign w_pulse[g] = w_rise_nxt | w_fall_nxt;
    assign Z[g]       = r_z;
    assign RISE[g]    = r_rise;
    assign FALL[g]    = r_fall;
    assign GLITCH[g]  = r_glitch;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= |w_pulse;
    end
  end

  assign CHG = r_chg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__antenna_sync_filter.sv
// Bench for the antenna sync filter: window-based reference model plus
// directed vectors with hand-computed expectations.
module tb_gf180mcu_fd_sc_mcu9t5v0__antenna_sync_filter;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int F  = 3;
  localparam int N  = 1200;
  localparam logic [W-1:0] INIT_V = '0;

  logic         CLK = 1'b0;
  logic         RN  = 1'b0;
  logic [W-1:0] I   = '1;
  logic         EN  = 1'b1;
  logic         CLR = 1'b0;
  logic [W-1:0] Z, RISE, FALL, GLITCH;
  logic         CHG;

  gf180mcu_fd_sc_mcu9t5v0__antenna_sync_filter #(
    .WIDTH(W), .SYNC_STAGES(SS), .FILT_CNT(F), .INIT(INIT_V)
  ) dut (
    .CLK(CLK), .RN(RN), .I(I), .EN(EN), .CLR(CLR),
    .Z(Z), .RISE(RISE), .FALL(FALL), .GLITCH(GLITCH), .CHG(CHG)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // reference state: raw sample and enable history per edge
  logic [W-1:0] ih  [N];
  bit           enh [N];
  int           t     = 0;
  int           rst_t = 0;
  int           lastchg [W];
  logic [W-1:0] mz, mrise, mfall, mglitch;
  logic         mchg;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] s_at(int k);
    if (k - SS >= rst_t) return ih[k-SS];
    return INIT_V;
  endfunction

  task automatic model_reset();
    mz      = INIT_V;
    mrise   = '0;
    mfall   = '0;
    mglitch = '0;
    mchg    = 1'b0;
    for (int c = 0; c < W; c++) lastchg[c] = -1;
  endtask

  // Z moves when the last F enabled evaluations all saw s != Z with no
  // intervening change; a glitch is an enabled s==Z right after an
  // enabled, non-completing s!=Z.
  task automatic model_update();
    int           e;
    int           k;
    bit           hit;
    bit           abort;
    logic [W-1:0] s, sk, sp, nz, nr, nf, ng;
    e      = t;
    ih[e]  = I;
    enh[e] = EN;
    s  = s_at(e);
    sp = s_at(e - 1);
    nz = mz;
    nr = '0;
    nf = '0;
    ng = mglitch & ~{W{CLR}};
    for (int c = 0; c < W; c++) begin
      hit = 1'b1;
      for (int j = 0; j < F; j++) begin
        k = e - j;
        if (k < rst_t) hit = 1'b0;
        else begin
          sk = s_at(k);
          if (!enh[k]) hit = 1'b0;
          else if (sk[c] == mz[c]) hit = 1'b0;
          else if (j > 0 && lastchg[c] >= k) hit = 1'b0;
        end
      end
      abort = 1'b0;
      if (enh[e] && s[c] == mz[c] && (e - 1 >= rst_t)) begin
        if (enh[e-1] && sp[c] != mz[c] && lastchg[c] != e - 1) abort = 1'b1;
      end
      if (hit) begin
        nz[c] = s[c];
        nr[c] = s[c];
        nf[c] = ~s[c];
        lastchg[c] = e;
      end
      if (abort) ng[c] = 1'b1;
    end
    mz      = nz;
    mrise   = nr;
    mfall   = nf;
    mglitch = ng;
    mchg    = |(nr | nf);
    t++;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      if (RN) model_update();
      #1;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      check("Z", Z, mz);
      check("RISE", RISE, mrise);
      check("FALL", FALL, mfall);
      check("GLITCH", GLITCH, mglitch);
      check("CHG", W'(CHG), W'(mchg));
    end
  end

  initial begin
    model_reset();
    chk_on = 1'b1;

    // reset with inputs high
    step(2);
    check("rst_Z", Z, 4'h0);
    check("rst_pulses", RISE | FALL, 4'h0);
    check("rst_GLITCH", GLITCH, 4'h0);

    I = '0;
    RN = 1'b1;
    rst_t = t;
    step(6);
    check("rel_Z", Z, 4'h0);

    // latency: Z changes on edge 4
    I = 4'b0001;
    step(4);
    check("lat_Z_e3", W'(Z[0]), 4'h0);
    step(1);
    check("lat_Z_e4", W'(Z[0]), 4'h1);
    check("lat_RISE_e4", W'(RISE[0]), 4'h1);
    check("lat_CHG_e4", W'(CHG), 4'h1);
    step(1);
    check("lat_RISE_e5", W'(RISE[0]), 4'h0);
    check("lat_CHG_e5", W'(CHG), 4'h0);

    // 2-cycle glitch on channel 1
    I = 4'b0011;
    step(2);
    I = 4'b0001;
    step(6);
    check("gl_Z1", W'(Z[1]), 4'h0);
    check("gl_G1", W'(GLITCH[1]), 4'h1);
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    check("gl_clr", W'(GLITCH[1]), 4'h0);

    // CLR coincident with a new abort: set wins
    I = 4'b0011;
    step(2);
    I = 4'b0001;
    step(2);
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    check("gl_setwins", W'(GLITCH[1]), 4'h1);
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    check("gl_clr2", W'(GLITCH[1]), 4'h0);

    // enable dropped mid-pend
    I = 4'b0101;
    step(3);
    EN = 1'b0;
    step(5);
    check("en_Z2", W'(Z[2]), 4'h0);
    check("en_G2", W'(GLITCH[2]), 4'h0);
    EN = 1'b1;
    step(2);
    check("en_Z2_pre", W'(Z[2]), 4'h0);
    step(1);
    check("en_Z2_post", W'(Z[2]), 4'h1);
    check("en_RISE2", W'(RISE[2]), 4'h1);
    I = 4'b0001;
    step(6);
    I = 4'b0000;
    step(8);

    // simultaneous multi-channel edges
    I = 4'b1010;
    step(4);
    check("mc_RISE_pre", RISE, 4'h0);
    step(1);
    check("mc_RISE", RISE, 4'b1010);
    check("mc_Z", Z, 4'b1010);
    step(1);
    check("mc_RISE_post", RISE, 4'h0);
    I = 4'b0000;
    step(4);
    step(1);
    check("mc_FALL", FALL, 4'b1010);
    step(2);

    // reset while channel 2 holds cnt=2
    I = 4'b0100;
    step(4);
    RN = 1'b0;
    model_reset();
    #1;
    check("mr_Z", Z, 4'h0);
    check("mr_G", GLITCH, 4'h0);
    step(3);
    I = 4'b0000;
    RN = 1'b1;
    rst_t = t;
    step(8);
    check("mr_Z_rel", Z, 4'h0);
    check("mr_pulse_rel", RISE | FALL, 4'h0);

    // mixed traffic against the model
    for (int n = 0; n < 60; n++) begin
      I   = W'($urandom);
      EN  = ($urandom_range(0, 7) != 0);
      CLR = ($urandom_range(0, 5) == 0);
      step($urandom_range(1, 4));
    end
    EN  = 1'b1;
    CLR = 1'b0;
    step(8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
